encode_pk: RTL and testbench
============================

# encode_pk

Packs a Kyber public key: captures the 256-bit seed rho, accepts the K·N coefficients of the public vector t one per cycle over a valid/ready handshake, reduces each to canonical form mod q, and assembles them into the flat public-key word. The bit layout is exactly the one `decode_pk` unpacks. The block sits at the tail of key generation, after the NTT/matrix-vector stage produces t, and its output feeds the public-key store or `decode_pk` directly.

## Interface
Parameters:
- KYBER_N, 256, coefficients per polynomial (and rho width in bits)
- KYBER_K, 3, polynomials in t
- KYBER_R_WIDTH, 12, bits per packed coefficient
- KYBER_Q, 3329, modulus

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new key; sampled only in IDLE or DONE
- rho_in  in  KYBER_N  seed, captured on accepted start
- coeff_in  in  KYBER_R_WIDTH  next t coefficient, range 0..4095
- coeff_valid  in  1  coeff_in is valid
- coeff_ready  out  1  block accepts a coefficient this cycle
- public_key  out  KYBER_N + KYBER_K·KYBER_R_WIDTH·KYBER_N  packed key
- busy  out  1  high in LOAD
- valid  out  1  public_key complete and stable

## Operation
- Layout: public_key[255:0] = rho. Coefficient j (0..767, poly i = j/256, index j%256) is placed at bits [256 + 12·j +: 12].
- Reduction: if coeff_in ≥ KYBER_Q, store coeff_in − KYBER_Q; otherwise store coeff_in. Width stays 12 bits. Inputs ≥ 2q (6658) cannot be represented in 12 bits, so none occur.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 → capture rho_in, clear the t region to 0, clear counter → LOAD.
  - LOAD: coeff_ready=1. Each cycle with coeff_valid && coeff_ready writes the reduced coefficient at index = counter and increments counter. The accept at counter = 767 → DONE. start is ignored in LOAD.
  - DONE: valid=1, public_key held. start=1 → same actions as from IDLE → LOAD, with valid dropping the next cycle.
- Counter: 10 bits. It never exceeds 767 and never wraps. The 768th accept always exits LOAD.
- coeff_valid outside LOAD is ignored and writes nothing.

## Timing
- Reset values: state IDLE; public_key all 0; counter 0; coeff_ready 0; busy 0; valid 0.
- Reset mid-LOAD: all state returns to the reset values on the next edge, and the partial key is discarded.
- Outputs are registered. coeff_ready and busy go high the cycle after start is accepted.
- Throughput: 1 coefficient per cycle. Minimum latency from start to valid is 769 cycles: 1 to enter LOAD, then 768 accepts.
- An accepted coefficient appears in public_key on the edge of acceptance, so it is visible the next cycle.
- valid rises the cycle after the final accept. It stays high until rst or an accepted restart.
- Bubbles (coeff_valid=0 in LOAD) stall the counter with no other effect.
- start and rst in the same cycle: rst wins.

## Test plan
- Reset: assert rst 2 cycles → public_key=0, valid=0, coeff_ready=0. Assert rst mid-LOAD at counter=100 → IDLE, public_key=0.
- Ramp: rho=0x0123…EF (32-byte pattern), coefficient j = j mod 3329 streamed with no bubbles → valid at cycle 769. Each 12-bit slot j equals j. Feed the result to `decode_pk` and check that rho and all three polynomials round-trip.
- Reduction: coefficients 3328, 3329, 4095, 0 at j=0..3 → stored 3328, 0, 766, 0.
- Backpressure and bubbles: random coeff_valid at 50% duty → all 768 values land in order. valid rises exactly one cycle after the 768th accept, and the counter never exceeds 767.
- Ignored inputs: start pulsed at counter=300 → no effect. coeff_valid=1 in IDLE/DONE → public_key unchanged.
- Restart from DONE: start with a new rho → valid drops next cycle, the t region reads 0, and the second key is correct after 768 more accepts.

Source files
------------

// File: rtl/encode_pk_if.sv
// rtl/encode_pk_if.sv - public-key packer bundle: seed, coefficient stream and packed key
interface encode_pk_if #(
    parameter int KYBER_N       = 256,
    parameter int KYBER_K       = 3,
    parameter int KYBER_R_WIDTH = 12
);
    logic                                             start;
    logic [KYBER_N-1:0]                               rho_in;
    logic [KYBER_R_WIDTH-1:0]                         coeff_in;
    logic                                             coeff_valid;
    logic                                             coeff_ready;
    logic [KYBER_N+KYBER_K*KYBER_R_WIDTH*KYBER_N-1:0] public_key;
    logic                                             busy;
    logic                                             valid;

    modport master (
        output start, rho_in, coeff_in, coeff_valid,
        input  coeff_ready, public_key, busy, valid
    );

    modport slave (
        input  start, rho_in, coeff_in, coeff_valid,
        output coeff_ready, public_key, busy, valid
    );
endinterface

// File: rtl/encode_pk.sv
// rtl/encode_pk.sv - Kyber public-key packer: rho plus K*N coefficients reduced mod q, 12 bits each
module encode_pk #(
    parameter int KYBER_N       = 256,
    parameter int KYBER_K       = 3,
    parameter int KYBER_R_WIDTH = 12,
    parameter int KYBER_Q       = 3329
) (
    input  logic        clk,
    input  logic        rst,
    encode_pk_if.slave  bus
);
    localparam int KEY_W = KYBER_N + KYBER_K * KYBER_R_WIDTH * KYBER_N;
    localparam int NCOEF = KYBER_K * KYBER_N;
    localparam logic [9:0] LAST_IDX = 10'(NCOEF - 1);
    localparam logic [KYBER_R_WIDTH-1:0] Q_R = KYBER_R_WIDTH'(KYBER_Q);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [9:0]               cnt_q, cnt_d;
    logic [KEY_W-1:0]         key_q, key_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic [KYBER_R_WIDTH-1:0] coeff_red;
    logic                     accept;

    // Inputs never reach 2q, so one conditional subtract gives the canonical residue.
    assign coeff_red = (bus.coeff_in >= Q_R) ? bus.coeff_in - Q_R : bus.coeff_in;
    assign accept    = (state_q == S_LOAD) && ready_q && bus.coeff_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    key_d                = '0;
                    key_d[KYBER_N-1:0]   = bus.rho_in;
                    cnt_d                = '0;
                    state_d              = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    key_d[KYBER_N + KYBER_R_WIDTH * int'(cnt_q) +: KYBER_R_WIDTH] = coeff_red;
                    // The counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.coeff_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.valid       = valid_q;
    assign bus.public_key  = key_q;
endmodule

// File: tb/tb_encode_pk.sv
// tb/tb_encode_pk.sv - directed bench for encode_pk with immediate assertions
module tb_encode_pk;
    localparam int N  = 256;
    localparam int K  = 3;
    localparam int R  = 12;
    localparam int Q  = 3329;
    localparam int KW = N + K * R * N;
    localparam int NC = K * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encode_pk_if #(.KYBER_N(N), .KYBER_K(K), .KYBER_R_WIDTH(R)) bus ();

    encode_pk #(.KYBER_N(N), .KYBER_K(K), .KYBER_R_WIDTH(R), .KYBER_Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [R-1:0]  coef [NC];
    logic [R-1:0]  expv [NC];
    logic [N-1:0]  exp_rho;
    logic [KW-1:0] exp_key;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp_key();
        exp_key = '0;
        exp_key[N-1:0] = exp_rho;
        for (int j = 0; j < NC; j++) exp_key[N + R * j +: R] = expv[j];
    endtask

    task automatic start_key(input logic [N-1:0] r);
        bus.rho_in = r;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        exp_rho    = r;
    endtask

    task automatic stream(input int n, input bit bubbles, input int pulse_at, input string tag);
        int idx = 0;
        int cyc = 0;
        bit early = 1'b0;
        bit v;
        bit acc;
        while (idx < n && cyc < 8 * NC) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.coeff_valid = v;
            bus.coeff_in    = coef[idx];
            bus.start       = (idx == pulse_at);
            if (bus.valid !== 1'b0) early = 1'b1;
            acc = v && (bus.coeff_ready === 1'b1);
            step();
            if (acc) begin
                idx++;
                if (idx == 1) chk({tag, " slot0 visible"}, bus.public_key[N +: R], expv[0]);
            end
            cyc++;
        end
        bus.coeff_valid = 1'b0;
        bus.start       = 1'b0;
        chk({tag, " accepts"}, idx, n);
        chk({tag, " valid before last accept"}, early, 0);
        if (!bubbles) chk({tag, " load cycles"}, cyc, n);
    endtask

    task automatic verify_key(input string tag);
        int errs;
        chk({tag, " rho"}, bus.public_key[N-1:0], exp_rho);
        for (int p = 0; p < K; p++) begin
            errs = 0;
            for (int i = 0; i < N; i++)
                if (bus.public_key[N + R * (p * N + i) +: R] !== expv[p * N + i]) errs++;
            chk($sformatf("%s poly%0d slot errors", tag, p), errs, 0);
        end
        build_exp_key();
        chk({tag, " full key"}, bus.public_key === exp_key, 1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.rho_in      = '0;
        bus.coeff_in    = '0;
        bus.coeff_valid = 1'b0;
        step();
        step();
        chk("reset key zero", bus.public_key === '0, 1);
        chk("reset valid", bus.valid, 0);
        chk("reset ready", bus.coeff_ready, 0);
        chk("reset busy", bus.busy, 0);
        rst = 1'b0;

        // Ramp key with a start pulse landing mid-load at index 300.
        for (int j = 0; j < NC; j++) begin
            coef[j] = R'(j);
            expv[j] = R'(j);
        end
        start_key({4{64'h0123456789ABCDEF}});
        chk("ramp ready after start", bus.coeff_ready, 1);
        chk("ramp busy after start", bus.busy, 1);
        chk("ramp valid after start", bus.valid, 0);
        stream(NC, 1'b0, 300, "ramp");
        chk("ramp valid", bus.valid, 1);
        chk("ramp ready in done", bus.coeff_ready, 0);
        chk("ramp busy in done", bus.busy, 0);
        verify_key("ramp");

        bus.coeff_valid = 1'b1;
        bus.coeff_in    = 12'hABC;
        step();
        step();
        step();
        bus.coeff_valid = 1'b0;
        chk("done ignores coeff key", bus.public_key === exp_key, 1);
        chk("done holds valid", bus.valid, 1);

        // Restart from DONE: reduction corner values then 4095-j with bubbles.
        for (int j = 0; j < NC; j++) begin
            coef[j] = R'(4095 - j);
            expv[j] = (j == 767) ? R'(3328) : R'(766 - j);
        end
        coef[0] = 12'd3328; expv[0] = 12'd3328;
        coef[1] = 12'd3329; expv[1] = 12'd0;
        coef[2] = 12'd4095; expv[2] = 12'd766;
        coef[3] = 12'd0;    expv[3] = 12'd0;
        start_key({4{64'hFEDCBA9876543210}});
        chk("restart valid drops", bus.valid, 0);
        chk("restart t region zero", bus.public_key[KW-1:N] === '0, 1);
        chk("restart rho", bus.public_key[N-1:0], {4{64'hFEDCBA9876543210}});
        chk("restart ready", bus.coeff_ready, 1);
        stream(NC, 1'b1, -1, "restart");
        chk("restart valid", bus.valid, 1);
        chk("restart ready in done", bus.coeff_ready, 0);
        chk("reduce slot1", bus.public_key[N + R * 1 +: R], 0);
        chk("reduce slot2", bus.public_key[N + R * 2 +: R], 766);
        verify_key("restart");

        // Reset after 100 accepts discards the partial key.
        for (int j = 0; j < NC; j++) begin
            coef[j] = R'(j);
            expv[j] = R'(j);
        end
        start_key({8{32'h5A5AA5A5}});
        stream(100, 1'b1, -1, "partial");
        chk("partial busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midload reset key zero", bus.public_key === '0, 1);
        chk("midload reset valid", bus.valid, 0);
        chk("midload reset ready", bus.coeff_ready, 0);
        chk("midload reset busy", bus.busy, 0);

        bus.coeff_valid = 1'b1;
        bus.coeff_in    = 12'd5;
        step();
        step();
        step();
        bus.coeff_valid = 1'b0;
        chk("idle ignores coeff key", bus.public_key === '0, 1);
        chk("idle ready", bus.coeff_ready, 0);

        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.rho_in = {8{32'hDEADBEEF}};
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst beats start busy", bus.busy, 0);
        chk("rst beats start key", bus.public_key === '0, 1);
        step();
        chk("rst beats start stays idle", bus.coeff_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
